md_issue_ctrl: RTL

- Initiator side of the multiply/divide unit interface, sitting between the E stage and the HI/LO unit.
- Decodes the E-stage md opcode and drives `md_op`, which the unit samples on the clock edge.
- Models the unit's busy window, stalls D-stage md instructions (including mfhi/mflo) until HI/LO are final, and suppresses issue when an exception or interrupt flushes E.

---
 rtl/md_issue_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: it decodes the E-stage md op, models the busy window and stalls D.
// The optional stall counter output (stall_cycles) is enabled with `define MD_STALL_STATS_EN.
module md_issue_ctrl #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       e_valid,
   input  logic [3:0] e_md_op,
   input  logic       e_flush,
   input  logic       d_md_use,
   output logic [3:0] md_op,
   output logic       md_busy,
   output logic       md_stall,
   output logic       hilo_rd,
   output logic       hilo_sel,
`ifdef MD_STALL_STATS_EN
   output logic [31:0] stall_cycles,
`endif
   output logic       proto_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_MUL_BUSY, ST_DIV_BUSY} state_t;

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             kind, kind_nxt;   // 0 = MUL, 1 = DIV
   logic             proto_err_nxt;
   state_t           state;

   logic ok, is_mul, is_div, is_start, is_mt, start_req, issue;

   assign ok        = e_valid & ~e_flush;
   assign is_mul    = (e_md_op == 4'd1) | (e_md_op == 4'd3);
   assign is_div    = (e_md_op == 4'd2) | (e_md_op == 4'd4);
   assign is_start  = is_mul | is_div;
   assign is_mt     = (e_md_op == 4'd7) | (e_md_op == 4'd8);
   assign start_req = ok & is_start;
   assign md_busy   = (cnt != '0);
   assign issue     = start_req & ~md_busy;

   assign md_op    = (issue | (ok & is_mt & ~md_busy)) ? e_md_op : 4'd0;
   assign md_stall = d_md_use & (issue | md_busy);
   assign hilo_rd  = ok & ((e_md_op == 4'd5) | (e_md_op == 4'd6));
   assign hilo_sel = (e_md_op == 4'd6);

   // The FSM state is a view of the counter plus the kind bit.
   assign state = (cnt == '0) ? ST_IDLE : (kind ? ST_DIV_BUSY : ST_MUL_BUSY);

   always_comb begin
      cnt_nxt       = cnt;
      kind_nxt      = kind;
      proto_err_nxt = proto_err;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               kind_nxt = is_div;
               cnt_nxt  = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end
         end
         ST_MUL_BUSY, ST_DIV_BUSY: begin
            cnt_nxt = cnt - 1'b1;
            // A start or mthi/mtlo that slipped past the stall is dropped and flagged.
            if (ok & (is_start | is_mt)) proto_err_nxt = 1'b1;
         end
         default: cnt_nxt = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         kind      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         kind      <= kind_nxt;
         proto_err <= proto_err_nxt;
      end
   end

`ifdef MD_STALL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        stall_cycles <= '0;
      else if (md_stall) stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule
